// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one sram_controller between
// NUM_REQ requesters. One transaction is in flight at a time. A command is
// issued only while the controller reports idle. The arbiter then waits for
// the controller to return to idle before it responds to the requester.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   req_valid/rw          per-requester request strobe and direction (1=read)
//   req_addr/req_wdata    packed per-requester address / write data slices
//   req_ack               one-hot pulse: request accepted
//   rsp_valid             one-hot pulse: transaction finished
//   rsp_rdata             read data (held across writes, zero on timeout)
//   rsp_err               qualifies rsp_valid: transaction timed out
//   err_sticky / err_clr  sticky timeout flag and its synchronous clear
//   mem/rw/addr/data_f2s  command interface to sram_controller
//   ready/data_s2f_r      controller idle flag and registered read data
module sram_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned AW          = 20,
    parameter int unsigned DW          = 16,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_rw,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic                  err_sticky,
    input  logic                  err_clr,
    output logic                  mem,
    output logic                  rw,
    output logic [AW-1:0]         addr,
    output logic [DW-1:0]         data_f2s,
    input  logic                  ready,
    input  logic [DW-1:0]         data_s2f_r
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = 8;

    typedef logic [NUM_REQ-1:0] req_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    req_vec_t      req_ack_d, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_d;
    logic          rsp_err_d, err_sticky_d, err_set;
    logic          mem_d, rw_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] data_f2s_d;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic          sel_rw;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Round-robin search: first valid requester after the last grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req_valid[IW'((32'(last_q) + k) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = IW'((32'(last_q) + k) % NUM_REQ);
            end
        end
    end

    // Winner's request slice.
    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                sel_rw    = req_rw[IW'(i)];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_d       = 1'b0;
        rw_d        = rw;
        addr_d      = addr;
        data_f2s_d  = data_f2s;
        req_ack_d   = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = 1'b0;
        err_set     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found && ready) begin
                    mem_d      = 1'b1;
                    rw_d       = sel_rw;
                    addr_d     = sel_addr;
                    data_f2s_d = sel_wdata;
                    req_ack_d  = req_vec_t'(1) << win_idx;
                    owner_d    = win_idx;
                    last_d     = win_idx;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // Controller back in idle: transaction complete.
                if (ready) begin
                    rsp_valid_d = req_vec_t'(1) << owner_q;
                    if (rw) begin
                        rsp_rdata_d = data_s2f_r;
                    end
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    rsp_valid_d = req_vec_t'(1) << owner_q;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    err_set     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear has priority over a timeout in the same cycle.
        if (err_clr) begin
            err_sticky_d = 1'b0;
        end else if (err_set) begin
            err_sticky_d = 1'b1;
        end else begin
            err_sticky_d = err_sticky;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            last_q     <= IW'(NUM_REQ - 1);
            owner_q    <= '0;
            cnt_q      <= '0;
            mem        <= 1'b0;
            rw         <= 1'b0;
            addr       <= '0;
            data_f2s   <= '0;
            req_ack    <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            mem        <= mem_d;
            rw         <= rw_d;
            addr       <= addr_d;
            data_f2s   <= data_f2s_d;
            req_ack    <= req_ack_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            rsp_err    <= rsp_err_d;
            err_sticky <= err_sticky_d;
        end
    end

    // Protocol invariants.
    a_ack_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(req_ack));
    a_rsp_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rsp_valid));
    a_mem_issue:  assert property (@(posedge clk) disable iff (!reset_n) mem |-> (state_q == ST_ISSUE));
    a_err_qual:   assert property (@(posedge clk) disable iff (!reset_n) rsp_err |-> (|rsp_valid));

endmodule
